// File: rtl/csync_gen.sv
// rtl/csync_gen.sv - registered RGB/sync output stage with selectable composite sync
//
// Ports:
//   clk_sys        system clock (shared with the scandoubler)
//   reset          asynchronous active-high reset
//   pixel_ena      pixel enable in; pixel_ena_out is this delayed one cycle
//   csync_mode     00 = hs ^ vs, 01 = hs | vs, 1x = serrated (falls back to hs | vs when unlocked)
//   hs_in, vs_in   active-high syncs
//   hb_in, vb_in   active-high blanking
//   r/g/b_in       pixel data
//   hs_out, vs_out, csync_out, blank_out, r/g/b_out, pixel_ena_out
//                  all registered one cycle after their inputs
//   locked         two consecutive identical hs periods seen, no saturation since
module csync_gen #(
    parameter int CNT_WIDTH   = 12,
    parameter int COLOR_DEPTH = 8
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   pixel_ena,
    input  logic [1:0]             csync_mode,
    input  logic                   hs_in,
    input  logic                   vs_in,
    input  logic                   hb_in,
    input  logic                   vb_in,
    input  logic [COLOR_DEPTH-1:0] r_in,
    input  logic [COLOR_DEPTH-1:0] g_in,
    input  logic [COLOR_DEPTH-1:0] b_in,
    output logic                   hs_out,
    output logic                   vs_out,
    output logic                   csync_out,
    output logic                   blank_out,
    output logic [COLOR_DEPTH-1:0] r_out,
    output logic [COLOR_DEPTH-1:0] g_out,
    output logic [COLOR_DEPTH-1:0] b_out,
    output logic                   pixel_ena_out,
    output logic                   locked
);

    localparam logic [CNT_WIDTH-1:0] PHASE_MAX = '1;

    logic                 hs_q;
    logic [CNT_WIDTH-1:0] phase_q, phase_d;
    logic [CNT_WIDTH-1:0] line_len_q, line_len_d;
    logic [CNT_WIDTH-1:0] hs_len_q, hs_len_d;
    logic                 locked_q, locked_d;
    logic                 csync_d;
    logic                 blank_d;

    logic                 hs_rise;
    logic                 hs_fall;
    logic [CNT_WIDTH-1:0] phase_inc;
    logic [CNT_WIDTH:0]   gap_start;
    logic                 no_gap;

    assign hs_rise   = hs_in & ~hs_q;
    assign hs_fall   = ~hs_in & hs_q;
    assign phase_inc = phase_q + CNT_WIDTH'(1);
    assign blank_d   = hb_in | vb_in;

    // One bit wider so hs_len >= line_len shows up as a negative or zero gap start.
    assign gap_start = {1'b0, line_len_q} - {1'b0, hs_len_q};
    assign no_gap    = gap_start[CNT_WIDTH] | (gap_start == '0);

    always_comb begin
        phase_d    = (phase_q == PHASE_MAX) ? phase_q : phase_inc;
        line_len_d = line_len_q;
        hs_len_d   = hs_len_q;
        locked_d   = locked_q;

        if (hs_rise) begin
            phase_d    = '0;
            line_len_d = phase_inc;
            // line_len_q still holds the previous period here.
            locked_d   = (phase_inc == line_len_q) && (line_len_q != '0);
        end else if (phase_d == PHASE_MAX) begin
            locked_d   = 1'b0;
        end

        if (hs_fall) begin
            hs_len_d = phase_inc;
        end
    end

    // phase_d is the phase of the current cycle (0 on the rise cycle), so the
    // gap covers the last hs_len cycles of the line and closes exactly when hs rises.
    always_comb begin
        csync_d = 1'b0;
        case (csync_mode)
            2'b00:   csync_d = hs_in ^ vs_in;
            2'b01:   csync_d = hs_in | vs_in;
            default: begin
                if (!locked_q) begin
                    csync_d = hs_in | vs_in;
                end else if (!vs_in) begin
                    csync_d = hs_in;
                end else if (no_gap) begin
                    csync_d = 1'b1;
                end else begin
                    csync_d = !({1'b0, phase_d} >= gap_start);
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hs_q          <= 1'b0;
            phase_q       <= '0;
            line_len_q    <= '0;
            hs_len_q      <= '0;
            locked_q      <= 1'b0;
            hs_out        <= 1'b0;
            vs_out        <= 1'b0;
            csync_out     <= 1'b0;
            blank_out     <= 1'b0;
            r_out         <= '0;
            g_out         <= '0;
            b_out         <= '0;
            pixel_ena_out <= 1'b0;
        end else begin
            hs_q          <= hs_in;
            phase_q       <= phase_d;
            line_len_q    <= line_len_d;
            hs_len_q      <= hs_len_d;
            locked_q      <= locked_d;
            hs_out        <= hs_in;
            vs_out        <= vs_in;
            csync_out     <= csync_d;
            blank_out     <= blank_d;
            r_out         <= blank_d ? '0 : r_in;
            g_out         <= blank_d ? '0 : g_in;
            b_out         <= blank_d ? '0 : b_in;
            pixel_ena_out <= pixel_ena;
        end
    end

    assign locked = locked_q;

endmodule

// File: tb/tb_csync_gen.sv
// tb/tb_csync_gen.sv - self-checking bench for csync_gen
module tb_csync_gen;

    localparam int PMAX = 4095;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       pixel_ena  = 1'b0;
    logic [1:0] csync_mode = 2'b10;
    logic       hs_in      = 1'b0;
    logic       vs_in      = 1'b0;
    logic       hb_in      = 1'b0;
    logic       vb_in      = 1'b0;
    logic [7:0] r_in       = 8'hAB;
    logic [7:0] g_in       = 8'hCD;
    logic [7:0] b_in       = 8'hEF;

    logic       hs_out, vs_out, csync_out, blank_out, pixel_ena_out, locked;
    logic [7:0] r_out, g_out, b_out;

    csync_gen #(.CNT_WIDTH(12), .COLOR_DEPTH(8)) dut (
        .clk_sys      (clk),
        .reset        (rst),
        .pixel_ena    (pixel_ena),
        .csync_mode   (csync_mode),
        .hs_in        (hs_in),
        .vs_in        (vs_in),
        .hb_in        (hb_in),
        .vb_in        (vb_in),
        .r_in         (r_in),
        .g_in         (g_in),
        .b_in         (b_in),
        .hs_out       (hs_out),
        .vs_out       (vs_out),
        .csync_out    (csync_out),
        .blank_out    (blank_out),
        .r_out        (r_out),
        .g_out        (g_out),
        .b_out        (b_out),
        .pixel_ena_out(pixel_ena_out),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Timestamp model: the phase is simply "cycles since the last hs rise",
    // clipped at the counter maximum; lengths are differences of timestamps.
    int   cyc, rise_cyc, m_line_len, m_hs_len;
    int   prev_ph, cur_ph, new_len;
    bit   m_locked, m_prev_hs, m_rise, m_fall, m_cs;
    logic e_hs, e_vs, e_cs, e_blank, e_pe;
    logic [7:0] e_r, e_g, e_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; rise_cyc = 0; m_line_len = 0; m_hs_len = 0;
            m_locked = 0; m_prev_hs = 0;
            e_hs = 0; e_vs = 0; e_cs = 0; e_blank = 0; e_pe = 0;
            e_r = 0; e_g = 0; e_b = 0;
        end else begin
            cyc++;
            prev_ph = imin(cyc - 1 - rise_cyc, PMAX);
            m_rise  = hs_in && !m_prev_hs;
            m_fall  = !hs_in && m_prev_hs;
            cur_ph  = m_rise ? 0 : imin(cyc - rise_cyc, PMAX);

            if (csync_mode == 2'b00)       m_cs = hs_in ^ vs_in;
            else if (csync_mode == 2'b01)  m_cs = hs_in | vs_in;
            else if (!m_locked)            m_cs = hs_in | vs_in;
            else if (!vs_in)               m_cs = hs_in;
            else if (m_hs_len >= m_line_len) m_cs = 1;
            else                           m_cs = (cur_ph < m_line_len - m_hs_len);

            if (m_rise) begin
                new_len    = (prev_ph + 1) % (PMAX + 1);
                m_locked   = (new_len == m_line_len) && (m_line_len != 0);
                m_line_len = new_len;
                rise_cyc   = cyc;
            end else if (cur_ph == PMAX) begin
                m_locked = 0;
            end
            if (m_fall) m_hs_len = (prev_ph + 1) % (PMAX + 1);
            m_prev_hs = hs_in;

            e_hs    = hs_in;
            e_vs    = vs_in;
            e_cs    = m_cs;
            e_blank = hb_in | vb_in;
            e_r     = (hb_in | vb_in) ? 8'h00 : r_in;
            e_g     = (hb_in | vb_in) ? 8'h00 : g_in;
            e_b     = (hb_in | vb_in) ? 8'h00 : b_in;
            e_pe    = pixel_ena;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hs_out", hs_out, e_hs);
            check("vs_out", vs_out, e_vs);
            check("csync_out", csync_out, e_cs);
            check("blank_out", blank_out, e_blank);
            check("r_out", r_out, e_r);
            check("g_out", g_out, e_g);
            check("b_out", b_out, e_b);
            check("pixel_ena_out", pixel_ena_out, e_pe);
            check("locked", locked, m_locked);
        end
    end

    logic       log_cs [0:199];
    logic       log_hs [0:199];
    logic [7:0] log_r  [0:15];
    logic       log_pe [0:15];
    int         zeros;

    task automatic run_line(input int period, input int width, input logic vs);
        for (int k = 0; k < period; k++) begin
            @(negedge clk);
            log_cs[k] = csync_out;
            log_hs[k] = hs_out;
            hs_in = (k < width);
            vs_in = vs;
        end
    endtask

    task automatic count_cs_zeros(input int lo, input int hi);
        zeros = 0;
        for (int k = lo; k <= hi; k++) if (log_cs[k] == 1'b0) zeros++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {hs_out, vs_out, csync_out, blank_out, pixel_ena_out, locked, r_out, g_out, b_out}, 0);
        rst = 0;
        pixel_ena = 1;
        chk_en = 1;

        // lock acquisition at 100/8
        run_line(100, 8, 0);
        check("lock_after_rise1", locked, 0);
        run_line(100, 8, 0);
        check("lock_after_rise2", locked, 0);
        run_line(100, 8, 0);
        check("lock_after_rise3", locked, 1);
        check("model_line_len", m_line_len, 100);
        check("model_hs_len", m_hs_len, 8);

        // serration over 3 vsync lines
        run_line(100, 8, 1);
        run_line(100, 8, 1);
        run_line(100, 8, 1);
        count_cs_zeros(0, 99);
        check("serr_gap_len", zeros, 8);
        check("serr_phase91", log_cs[92], 1);
        check("serr_phase92", log_cs[93], 0);
        check("serr_prev_phase99", log_cs[0], 0);
        check("serr_phase0", log_cs[1], 1);
        run_line(100, 8, 0);
        check("serr_last_gap", log_cs[0], 0);
        check("serr_hs_out_rise", log_hs[1], 1);
        check("serr_cs_rise_with_hs", log_cs[1], 1);

        // unlock by one long period, then relock
        run_line(120, 8, 0);
        check("still_locked_before_long", locked, 1);
        run_line(100, 8, 1);
        check("unlocked_after_long", locked, 0);
        count_cs_zeros(1, 99);
        check("unlocked_cs_hs_or_vs", zeros, 0);
        run_line(100, 8, 0);
        check("unlocked_one_match", locked, 0);
        run_line(100, 8, 0);
        check("relocked", locked, 1);

        // simple modes
        @(negedge clk);
        csync_mode = 2'b00; hs_in = 1; vs_in = 1;
        @(negedge clk);
        check("mode00_xor", csync_out, 0);
        csync_mode = 2'b01;
        @(negedge clk);
        check("mode01_or", csync_out, 1);
        hs_in = 0; vs_in = 0; csync_mode = 2'b10;

        // blanking and alignment
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            log_r[k]  = r_out;
            log_pe[k] = pixel_ena_out;
            hb_in     = (k >= 3 && k < 7);
            pixel_ena = ((k % 2) == 1);
        end
        zeros = 0;
        for (int k = 0; k <= 12; k++) if (log_r[k] == 8'h00) zeros++;
        check("blank_cycles", zeros, 4);
        check("blank_before", log_r[3], 8'hAB);
        check("blank_first", log_r[4], 8'h00);
        check("blank_last", log_r[7], 8'h00);
        check("blank_after", log_r[8], 8'hAB);
        check("pe_delay_a", log_pe[5], 0);
        check("pe_delay_b", log_pe[6], 1);
        pixel_ena = 1;

        // relock, then saturate
        run_line(100, 8, 0);
        run_line(100, 8, 0);
        run_line(100, 8, 0);
        check("locked_before_sat", locked, 1);
        repeat (4100) begin
            @(negedge clk);
            hs_in = 0;
        end
        check("unlocked_at_sat", locked, 0);

        // asynchronous reset mid-cycle
        @(negedge clk);
        hs_in = 1; vs_in = 1;
        @(negedge clk);
        check("pre_reset_hs", hs_out, 1);
        check("pre_reset_r", r_out, 8'hAB);
        #2 rst = 1;
        #1;
        check("async_reset_syncs", {hs_out, vs_out, csync_out, blank_out}, 0);
        check("async_reset_rgb", {r_out, g_out, b_out}, 0);
        check("async_reset_pe_lock", {pixel_ena_out, locked}, 0);
        @(negedge clk);
        rst = 0; hs_in = 0; vs_in = 0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
